// File: rtl/ifetch_buf.sv
// Instruction fetch: direct-mapped iCache with block refill FSM, an in-order instruction
// queue towards the decoder, and an optional 2-bit branch predictor (define IFETCH_BHT_EN).
module ifetch_buf #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BLK_NUM   = 16,
    parameter int          BLK_BYTES = 64,
    parameter int          IQ_DEPTH  = 4,
    parameter int          BHT_SIZE  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [31:0]            dec_inst,
    output logic [31:0]            dec_pc,
    output logic                   dec_pred_jump,
    output logic                   memc_en,
    output logic [31:0]            memc_pc,
    input  logic                   memc_done,
    input  logic [BLK_BYTES*8-1:0] memc_data,
    input  logic                   redirect_en,
    input  logic [31:0]            redirect_pc,
    input  logic                   br_en,
    input  logic                   br_taken,
    input  logic [31:0]            br_pc
);
    localparam int OFF_W = $clog2(BLK_BYTES) - 2;
    localparam int IDX_W = $clog2(BLK_NUM);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam logic [PTR_W:0] IQ_FULL = (PTR_W+1)'(IQ_DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state_q, state_d;

    logic [BLK_NUM-1:0]     valid_q;
    logic [TAG_W-1:0]       tag_mem  [BLK_NUM];
    logic [BLK_BYTES*8-1:0] data_mem [BLK_NUM];

    logic [31:0]         pc_q, next_pc;
    logic [31:0]         q_inst [IQ_DEPTH];
    logic [31:0]         q_pc   [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] q_pred;
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [PTR_W:0]      count_q;

    logic [IDX_W-1:0] idx, fill_idx;
    logic [OFF_W-1:0] off;
    logic [TAG_W-1:0] tag, fill_tag;
    logic [31:0]      inst, j_imm, b_imm;
    logic             hit, enq, deq, pred, bht_taken, is_jal, is_br;
    logic             issue, install;

    assign idx      = pc_q[2+OFF_W +: IDX_W];
    assign off      = pc_q[2 +: OFF_W];
    assign tag      = pc_q[31 -: TAG_W];
    assign fill_idx = memc_pc[2+OFF_W +: IDX_W];
    assign fill_tag = memc_pc[31 -: TAG_W];
    assign hit      = valid_q[idx] && (tag_mem[idx] == tag);
    assign inst     = data_mem[idx][32*off +: 32];

    assign is_jal = (inst[6:0] == 7'b1101111);
    assign is_br  = (inst[6:0] == 7'b1100011);
    assign j_imm  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign b_imm  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

`ifdef IFETCH_BHT_EN
    localparam int BHT_W = $clog2(BHT_SIZE);
    logic [1:0]       bht [BHT_SIZE];
    logic [BHT_W-1:0] br_idx;
    logic             unused_br;

    assign br_idx    = br_pc[2 +: BHT_W];
    assign bht_taken = bht[pc_q[2 +: BHT_W]][1];
    assign unused_br = ^{br_pc[31:BHT_W+2], br_pc[1:0]};

    // Saturating counters; a same-cycle lookup sees the pre-update value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'd0;
        end else if (rdy && br_en) begin
            if (br_taken && bht[br_idx] != 2'd3)
                bht[br_idx] <= bht[br_idx] + 2'd1;
            else if (!br_taken && bht[br_idx] != 2'd0)
                bht[br_idx] <= bht[br_idx] - 2'd1;
        end
    end
`else
    logic unused_br;
    assign bht_taken = 1'b0;
    assign unused_br = ^{br_en, br_taken, br_pc, BHT_SIZE[0]};
`endif

    always_comb begin
        pred    = 1'b0;
        next_pc = pc_q + 32'd4;
        if (is_jal) begin
            pred    = 1'b1;
            next_pc = pc_q + j_imm;
        end else if (is_br && bht_taken) begin
            pred    = 1'b1;
            next_pc = pc_q + b_imm;
        end
    end

    assign dec_valid     = (count_q != '0);
    assign dec_inst      = q_inst[head_q];
    assign dec_pc        = q_pc[head_q];
    assign dec_pred_jump = q_pred[head_q];
    assign deq           = dec_valid && dec_ready;
    assign enq           = hit && ((count_q != IQ_FULL) || deq);

    // A redirect suppresses a new refill, but an outstanding one always completes.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        install = 1'b0;
        case (state_q)
            S_IDLE: if (!hit && !redirect_en) begin
                issue   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: if (memc_done) begin
                install = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            valid_q <= '0;
            memc_en <= 1'b0;
            memc_pc <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            if (issue) begin
                memc_en <= 1'b1;
                memc_pc <= {pc_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            end
            if (install) begin
                memc_en           <= 1'b0;
                valid_q[fill_idx] <= 1'b1;
            end
            if (redirect_en) begin
                pc_q    <= redirect_pc;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (enq) begin
                    pc_q   <= next_pc;
                    tail_q <= tail_q + 1'b1;
                end
                if (deq) head_q <= head_q + 1'b1;
                case ({enq, deq})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Storage arrays carry no reset; valid bits and queue count qualify them.
    always_ff @(posedge clk) begin
        if (!rst && rdy && install) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= memc_data;
        end
        if (!rst && rdy && !redirect_en && enq) begin
            q_inst[tail_q] <= inst;
            q_pc[tail_q]   <= pc_q;
            q_pred[tail_q] <= pred;
        end
    end
endmodule

// File: tb/tb_ifetch_buf.sv
// Scoreboard bench for ifetch_buf: random program, random handshakes/redirects/branch updates,
// expected fetch stream derived from program jump targets and a counter-table model.
module tb_ifetch_buf;
    localparam int BLK_BYTES  = 64;
    localparam int WORDS      = BLK_BYTES / 4;
    localparam int PROG_WORDS = 256;

    logic                   clk, rst, rdy;
    logic                   dec_valid, dec_ready, dec_pred_jump;
    logic [31:0]            dec_inst, dec_pc;
    logic                   memc_en, memc_done;
    logic [31:0]            memc_pc;
    logic [BLK_BYTES*8-1:0] memc_data;
    logic                   redirect_en, br_en, br_taken;
    logic [31:0]            redirect_pc, br_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] br_list[$];
    logic [31:0] prog [PROG_WORDS];
    logic [31:0] tgt  [PROG_WORDS];
    int          kind [PROG_WORDS];
    int          bht_m[PROG_WORDS];
    int          checks = 0;
    int          failures = 0;
    int          deq_count = 0;

    ifetch_buf #(
        .RESET_PC(32'h0), .BLK_NUM(16), .BLK_BYTES(BLK_BYTES), .IQ_DEPTH(4), .BHT_SIZE(256)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
        .dec_pred_jump(dec_pred_jump),
        .memc_en(memc_en), .memc_pc(memc_pc), .memc_done(memc_done), .memc_data(memc_data),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .br_en(br_en), .br_taken(br_taken), .br_pc(br_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [31:0] enc_jal(input logic [31:0] off);
        logic [20:0] im;
        im = off[20:0];
        return {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [31:0] off);
        logic [12:0] im;
        im = off[12:0];
        return {im[12], im[10:5], 5'd2, 5'd3, 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd1024) return prog[a[9:2]];
        return 32'h00000013;
    endfunction

    // Expected fetch order: follow jump targets of the program, branches only when counter >= 2.
    function automatic void model_fill(input logic [31:0] start);
        logic [31:0] p;
        exp_t        e;
        p = start;
        exp_q.delete();
        for (int n = 0; n < 2048; n++) begin
            e.pc   = p;
            e.inst = mem_word(p);
            e.pred = 1'b0;
            if (p < 32'd1024 && kind[p[9:2]] == 1) begin
                e.pred = 1'b1;
                p      = tgt[p[9:2]];
            end
`ifdef IFETCH_BHT_EN
            else if (p < 32'd1024 && kind[p[9:2]] == 2 && bht_m[p[9:2]] >= 2) begin
                e.pred = 1'b1;
                p      = tgt[p[9:2]];
            end
`endif
            else begin
                p = p + 32'd4;
            end
            exp_q.push_back(e);
        end
    endfunction

    function automatic void reset_model();
        for (int i = 0; i < PROG_WORDS; i++) bht_m[i] = 0;
        model_fill(32'h0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles, input int ready_pct, input int stall_pct);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            dec_ready = ($urandom_range(0, 99) < 32'(ready_pct));
            rdy       = ($urandom_range(0, 99) >= 32'(stall_pct));
        end
    endtask

    task automatic doReset(input int n);
        @(posedge clk); #1;
        rst = 1'b1; redirect_en = 1'b0; br_en = 1'b0; dec_ready = 1'b0; rdy = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        checkOutput("rst_dec_valid", dec_valid, 32'd0);
        checkOutput("rst_memc_en", memc_en, 32'd0);
        checkOutput("rst_memc_pc", memc_pc, 32'd0);
        reset_model();
        rst = 1'b0;
    endtask

    // Branch outcomes are only applied while redirecting, so no fetch can race the counter update.
    task automatic doRedirect(input logic [31:0] target, input int ncyc, input bit force40);
        int nbr;
        nbr = (br_list.size() < 6) ? br_list.size() : 6;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            rdy         = 1'b1;
            redirect_en = 1'b1;
            redirect_pc = target;
            dec_ready   = 1'($urandom_range(0, 1));
            br_en       = force40 ? 1'b1 : ($urandom_range(0, 3) != 0);
            br_taken    = force40 ? 1'b1 : ($urandom_range(0, 3) != 0);
            br_pc       = force40 ? 32'h40 : br_list[$urandom_range(0, nbr - 1)];
            if (br_en) begin
                if (br_taken && bht_m[br_pc[9:2]] < 3) bht_m[br_pc[9:2]]++;
                else if (!br_taken && bht_m[br_pc[9:2]] > 0) bht_m[br_pc[9:2]]--;
            end
        end
        model_fill(target);
        @(posedge clk); #1;
        redirect_en = 1'b0;
        br_en       = 1'b0;
        dec_ready   = 1'b0;
        @(negedge clk);
        checkOutput("flush_empty", dec_valid, 32'd0);
    endtask

    always begin
        @(negedge clk);
        if (memc_en === 1'b1) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int k = 0; k < WORDS; k++) memc_data[32*k +: 32] = mem_word(memc_pc + 32'(4*k));
            memc_done = 1'b1;
            @(negedge clk);
            memc_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && rdy && !redirect_en && dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("deq_pc", dec_pc, e.pc);
                checkOutput("deq_inst", dec_inst, e.inst);
                checkOutput("deq_pred", dec_pred_jump, e.pred);
                deq_count++;
            end
        end
    end

    initial begin
        int r;
        bit found;
        rst = 1'b1; rdy = 1'b1; dec_ready = 1'b0; memc_done = 1'b0; memc_data = '0;
        redirect_en = 1'b0; redirect_pc = '0; br_en = 1'b0; br_taken = 1'b0; br_pc = '0;

        for (int i = 0; i < PROG_WORDS; i++) begin
            r       = int'($urandom_range(0, 99));
            tgt[i]  = 32'($urandom_range(0, PROG_WORDS - 1)) * 32'd4;
            if (i == 2) begin
                kind[i] = 1; tgt[i] = 32'h28;
            end else if (i == 16) begin
                kind[i] = 2; tgt[i] = 32'h38;
            end else if (r < 10) kind[i] = 1;
            else if (r < 25) kind[i] = 2;
            else if (r < 30) kind[i] = 3;
            else kind[i] = 0;
            case (kind[i])
                1:       prog[i] = enc_jal(tgt[i] - 32'(4*i));
                2:       prog[i] = enc_beq(tgt[i] - 32'(4*i));
                3:       prog[i] = {12'($urandom_range(0, 4095)), 5'd1, 3'b000, 5'd0, 7'b1100111};
                default: prog[i] = {12'($urandom_range(0, 4095)), 5'($urandom_range(0, 31)), 3'b000,
                                    5'($urandom_range(0, 31)), 7'b0010011};
            endcase
        end
        br_list.push_back(32'h40);
        for (int i = 0; i < PROG_WORDS; i++)
            if (kind[i] == 2 && i != 16) br_list.push_back(32'(4*i));

        doReset(3);
        @(posedge clk); #1;
        checkOutput("first_miss_memc_en", memc_en, 32'd1);
        checkOutput("first_miss_memc_pc", memc_pc, 32'd0);

        applyStimulus(30, 0, 0);
        @(negedge clk);
        checkOutput("stall_dec_valid", dec_valid, 32'd1);
        checkOutput("stall_head_pc", dec_pc, 32'h0);

        applyStimulus(400, 80, 10);

        doRedirect(32'h40, 2, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (dec_valid) found = 1'b1;
        end
        checkOutput("beq_enqueued", found, 32'd1);
        checkOutput("beq_pc", dec_pc, 32'h40);
`ifdef IFETCH_BHT_EN
        checkOutput("beq_pred", dec_pred_jump, 32'd1);
`else
        checkOutput("beq_pred", dec_pred_jump, 32'd0);
`endif
        applyStimulus(100, 80, 10);

        for (int n = 0; n < 12; n++) begin
            logic [31:0] t;
            if ($urandom_range(0, 1) == 0) t = 32'($urandom_range(0, 255)) * 32'd4;
            else t = 32'($urandom_range(256, 1023)) * 32'd4;
            doRedirect(t, int'($urandom_range(1, 5)), 1'b0);
            applyStimulus(int'($urandom_range(50, 150)), 80, 10);
        end

        doRedirect(32'h2000, 1, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            rdy = 1'b1;
            if (memc_en) found = 1'b1;
        end
        checkOutput("refill_seen", found, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid_refill_memc_en", memc_en, 32'd0);
        checkOutput("rst_mid_refill_dec_valid", dec_valid, 32'd0);
        reset_model();
        rst = 1'b0;
        applyStimulus(200, 80, 10);

        checkOutput("progress", 32'(deq_count > 400), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
